// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: the arbiter state encoding,
// the default byte width agreed with the transmitter, and a width helper.
package uart_pkg;

  // Byte width used by both the transmitter and its arbiter.
  localparam int UART_DATA_WIDTH = 8;

  // Arbiter sequencing states. The numeric encoding is fixed so that older
  // logic decoding the raw 2-bit state keeps working.
  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_ISSUE     = 2'd1,
    ARB_WAIT_BUSY = 2'd2,
    ARB_WAIT_DONE = 2'd3
  } arb_state_e;

  // Number of bits needed to index n items. The result is never below 1, so
  // index ports keep a legal width even for tiny n.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector. The search starts one past the pointer,
// wraps at N_REQ, and returns the first active request it finds. This block
// is shared with the receive-side routers, so it holds no state of its own.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int  N_REQ = 4,
  localparam int IDX_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] pointer_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] index_o
);

  // Walk the requesters in priority order; the first hit wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    valid_o = 1'b0;
    index_o = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(pointer_i) + k) % N_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        index_o = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte
// producers. Each transfer is sequenced as: latch the winner's byte and ack
// it, pulse start, confirm the transmitter went busy, then wait for it to be
// idle again. Only one frame is ever in flight. If the transmitter never goes
// busy, the byte is dropped and a sticky timeout flag is raised.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int  N_REQ        = 4,
  parameter int  DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int  BUSY_TIMEOUT = 15,
  localparam int IDX_W        = clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            ack,
  output logic                        tx_start,
  output logic [DATA_WIDTH-1:0]       tx_data,
  input  logic                        tx_ready,
  output logic                        busy,
  output logic [IDX_W-1:0]            grant_id,
  output logic                        err_timeout
);

  // Raw state constants, kept numerically identical to the package enum.
  localparam logic [1:0] S_IDLE      = ARB_IDLE;
  localparam logic [1:0] S_ISSUE     = ARB_ISSUE;
  localparam logic [1:0] S_WAIT_BUSY = ARB_WAIT_BUSY;
  localparam logic [1:0] S_WAIT_DONE = ARB_WAIT_DONE;

  // The timeout limit never exceeds 255, so an 8-bit counter covers it.
  localparam logic [7:0] CNT_LIMIT = 8'(BUSY_TIMEOUT);

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [N_REQ-1:0]      ack_q, ack_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;

  uart_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_i     (req),
    .pointer_i (ptr_q),
    .valid_o   (pick_valid),
    .index_o   (pick_idx)
  );

  // Next-state logic for the sequencer, data latch, ack pulse and timeout.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    ack_d   = '0;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        // req is only looked at here; while busy it is ignored.
        if (tx_ready && pick_valid) begin
          data_d          = req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          grant_d         = pick_idx;
          ptr_d           = pick_idx;
          ack_d[pick_idx] = 1'b1;
          state_d         = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!tx_ready) begin
          state_d = S_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == CNT_LIMIT) begin
            // The transmitter never took the byte: drop it, do not retry.
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset aborts any sequencing but
  // leaves the transmitter itself alone.
  always_ff @(posedge clk) begin
    // NOTE: registers are written with non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement order.
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= IDX_W'(N_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign ack         = ack_q;
  assign tx_start    = (state_q == S_ISSUE);
  assign tx_data     = data_q;
  assign busy        = (state_q != S_IDLE);
  assign grant_id    = grant_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: the arbiter drives a behavioural UART
// transmitter (50 MHz clock, shortened bit time), and a line monitor decodes
// the serial output back into bytes. Arbitration order is predicted from the
// round-robin rule kept in ptr_m.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N_REQ        = 4;
  localparam int DW           = 8;
  localparam int BUSY_TIMEOUT = 15;
  localparam int IDX_W        = 2;
  localparam int CPB          = 8;            // clocks per serial bit
  localparam int FRAME_BUDGET = 20 * CPB;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N_REQ-1:0]     req;
  logic [N_REQ*DW-1:0]  req_data;
  logic [N_REQ-1:0]     ack;
  logic                 tx_start;
  logic [DW-1:0]        tx_data;
  logic                 tx_ready;
  logic                 busy;
  logic [IDX_W-1:0]     grant_id;
  logic                 err_timeout;

  int checks   = 0;
  int failures = 0;
  int ptr_m;                                  // reference round-robin pointer

  always #10 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ        (N_REQ),
    .DATA_WIDTH   (DW),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .grant_id    (grant_id),
    .err_timeout (err_timeout)
  );

  // Transmitter model: start bit, 8 data bits LSB first, stop bit.
  logic       m_rst, m_stuck, m_ready, m_active, line;
  logic [9:0] m_frame;
  int         m_cnt, m_bit, starts;

  always @(posedge clk) begin
    if (m_rst) begin
      m_ready <= 1'b1; line <= 1'b1; m_active <= 1'b0;
      m_cnt <= 0; m_bit <= 0; starts <= 0; m_frame <= '1;
    end else begin
      if (tx_start === 1'b1) starts <= starts + 1;
      if (m_active) begin
        if (m_cnt == CPB - 1) begin
          m_cnt <= 0;
          if (m_bit == 9) begin
            m_active <= 1'b0; m_ready <= 1'b1; line <= 1'b1;
          end else begin
            m_bit <= m_bit + 1; line <= m_frame[m_bit + 1];
          end
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end else if (tx_start === 1'b1 && m_ready && !m_stuck) begin
        m_active <= 1'b1; m_ready <= 1'b0; line <= 1'b0;
        m_frame <= {1'b1, tx_data, 1'b0}; m_bit <= 0; m_cnt <= 0;
      end
    end
  end
  assign tx_ready = m_ready;

  // Line monitor: samples mid-bit and rebuilds each transmitted byte.
  logic [7:0] rx_q[$];
  int         frame_errs;
  initial begin
    logic [7:0] b;
    frame_errs = 0;
    b = '0;
    forever begin
      @(negedge line);
      repeat (CPB / 2) @(negedge clk);
      if (line !== 1'b0) frame_errs++;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = line;
      end
      repeat (CPB) @(negedge clk);
      if (line !== 1'b1) frame_errs++;
      rx_q.push_back(b);
    end
  end

  function automatic logic [N_REQ-1:0] onehot(input int i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Round-robin rule: search from ptr_m+1, wrapping, first active wins.
  function automatic int model_pick(input logic [N_REQ-1:0] r);
    for (int k = 1; k <= N_REQ; k++) begin
      int i;
      i = (ptr_m + k) % N_REQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    ptr_m = N_REQ - 1;
  endtask

  task automatic wait_ack(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (|ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (busy === 1'b0 && tx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    req = 4'b0001;
    req_data[7:0] = 8'h11;
    tick(2);
    checks++; if (ack !== '0) begin failures++; $display("FAIL reset_ack: got %b want 0", ack); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    checks++; if (tx_data !== '0) begin failures++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (grant_id !== '0) begin failures++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err_timeout); end
    req   = '0;
    reset = 1'b0;
    ptr_m = N_REQ - 1;
    tick(3);
    checks++; if (busy !== 1'b0 || starts != 0) begin
      failures++; $display("FAIL reset_idle_quiet: busy=%b starts=%0d want 0/0", busy, starts);
    end
  endtask

  task automatic test_single();
    bit ok; int s0, w;
    rx_q.delete();
    s0 = starts;
    req_data[7:0] = 8'h55;
    req = 4'b0001;
    w = model_pick(req); ptr_m = w;
    wait_ack(10, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_ack_wait: no ack within 10 cycles"); end
    else begin
      checks++; if (ack !== onehot(w)) begin failures++; $display("FAIL single_ack: got %b want %b", ack, onehot(w)); end
      checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL single_start: got %b want 1", tx_start); end
      checks++; if (grant_id !== IDX_W'(w)) begin failures++; $display("FAIL single_grant: got %0d want %0d", grant_id, w); end
    end
    req = '0;
    @(negedge clk);
    checks++; if (ack !== '0 || tx_start !== 1'b0) begin
      failures++; $display("FAIL single_pulse_width: ack=%b start=%b want 0/0", ack, tx_start);
    end
    ok = 1'b0;
    for (int c = 0; c < FRAME_BUDGET; c++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || tx_ready !== 1'b1) begin
      failures++; $display("FAIL single_busy_fall: fell=%b tx_ready=%b want 1/1", ok, tx_ready);
    end
    checks++; if (starts - s0 != 1) begin failures++; $display("FAIL single_start_count: got %0d want 1", starts - s0); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
      failures++; $display("FAIL single_line_byte: got %0d bytes first %h want 1 byte 55", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00);
    end
    checks++; if (frame_errs != 0) begin failures++; $display("FAIL single_framing: got %0d errors want 0", frame_errs); end
  endtask

  task automatic test_all_requesters();
    bit ok; int w; int order[5]; logic [7:0] ew;
    do_reset();
    rx_q.delete();
    for (int i = 0; i < N_REQ; i++) req_data[i*DW +: DW] = 8'(8'hA0 + i);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      w = model_pick(req); ptr_m = w; order[n] = w;
      wait_ack(FRAME_BUDGET, ok);
      checks++; if (!ok) begin failures++; $display("FAIL all_ack_wait[%0d]: no ack", n); break; end
      ew = 8'(8'hA0 + w);
      checks++; if (ack !== onehot(w)) begin failures++; $display("FAIL all_ack[%0d]: got %b want %b", n, ack, onehot(w)); end
      checks++; if (tx_data !== ew) begin failures++; $display("FAIL all_tx_data[%0d]: got %h want %h", n, tx_data, ew); end
    end
    req = '0;
    wait_idle(FRAME_BUDGET, ok);
    checks++; if (!ok || rx_q.size() != 5) begin
      failures++; $display("FAIL all_frame_count: idle=%b got %0d frames want 5", ok, rx_q.size());
    end else begin
      for (int n = 0; n < 5; n++) begin
        ew = 8'(8'hA0 + order[n]);
        checks++; if (rx_q[n] !== ew) begin failures++; $display("FAIL all_order[%0d]: got %h want %h", n, rx_q[n], ew); end
      end
    end
  endtask

  task automatic test_wrap();
    bit ok; int w;
    logic [N_REQ-1:0] pat[3];
    logic [7:0] exp_b[3];
    pat[0] = 4'b1000; pat[1] = 4'b1001; pat[2] = 4'b1000;
    do_reset();
    rx_q.delete();
    req_data[31:24] = 8'h3C;
    req_data[7:0]   = 8'hC0;
    for (int n = 0; n < 3; n++) begin
      req = pat[n];
      w = model_pick(req); ptr_m = w;
      exp_b[n] = req_data[w*DW +: DW];
      wait_ack(FRAME_BUDGET, ok);
      checks++; if (!ok) begin failures++; $display("FAIL wrap_ack_wait[%0d]: no ack", n); break; end
      checks++; if (ack !== onehot(w) || grant_id !== IDX_W'(w)) begin
        failures++; $display("FAIL wrap_grant[%0d]: ack=%b id=%0d want %b/%0d", n, ack, grant_id, onehot(w), w);
      end
    end
    req = '0;
    wait_idle(FRAME_BUDGET, ok);
    checks++; if (!ok || rx_q.size() != 3) begin
      failures++; $display("FAIL wrap_frames: idle=%b got %0d want 3", ok, rx_q.size());
    end else begin
      for (int n = 0; n < 3; n++) begin
        checks++; if (rx_q[n] !== exp_b[n]) begin failures++; $display("FAIL wrap_byte[%0d]: got %h want %h", n, rx_q[n], exp_b[n]); end
      end
    end
  endtask

  task automatic test_stuck();
    bit ok; int s0, w, first; logic busy_at; logic [7:0] b;
    rx_q.delete();
    m_stuck = 1'b1;
    s0 = starts;
    req_data[23:16] = 8'($urandom);
    req = 4'b0100;
    w = model_pick(req); ptr_m = w;
    wait_ack(10, ok);
    checks++; if (!ok || ack !== onehot(w)) begin failures++; $display("FAIL stuck_ack: got %b want %b", ack, onehot(w)); end
    req = '0;
    first = -1; busy_at = 1'bx;
    for (int k = 1; k <= BUSY_TIMEOUT + 4; k++) begin
      @(negedge clk);
      if (first < 0 && err_timeout === 1'b1) begin first = k; busy_at = busy; end
    end
    // ack is seen in ISSUE; WAIT_BUSY starts one edge later.
    checks++; if (first != BUSY_TIMEOUT + 1) begin
      failures++; $display("FAIL stuck_err_time: got %0d want %0d", first, BUSY_TIMEOUT + 1);
    end
    checks++; if (busy_at !== 1'b0) begin failures++; $display("FAIL stuck_back_idle: busy=%b want 0", busy_at); end
    checks++; if (starts - s0 != 1 || rx_q.size() != 0) begin
      failures++; $display("FAIL stuck_no_retry: starts=%0d frames=%0d want 1/0", starts - s0, rx_q.size());
    end
    m_stuck = 1'b0;
    b = 8'($urandom);
    req_data[15:8] = b;
    req = 4'b0010;
    w = model_pick(req); ptr_m = w;
    wait_ack(10, ok);
    checks++; if (!ok || ack !== onehot(w)) begin failures++; $display("FAIL stuck_next_ack: got %b want %b", ack, onehot(w)); end
    req = '0;
    wait_idle(FRAME_BUDGET, ok);
    checks++; if (!ok || rx_q.size() != 1 || rx_q[0] !== b) begin
      failures++; $display("FAIL stuck_next_frame: frames=%0d want 1 byte %h", rx_q.size(), b);
    end
    checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL stuck_sticky: got %b want 1", err_timeout); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok; int w, s0; logic [7:0] b0, b2; bit early;
    rx_q.delete();
    b0 = 8'($urandom); b2 = 8'($urandom);
    req_data[7:0] = b0;
    req = 4'b0001;
    w = model_pick(req); ptr_m = w;
    wait_ack(10, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_ack_wait: no ack"); end
    req = '0;
    tick(3 * CPB);
    checks++; if (busy !== 1'b1 || tx_ready !== 1'b0) begin
      failures++; $display("FAIL mid_in_frame: busy=%b tx_ready=%b want 1/0", busy, tx_ready);
    end
    req_data[23:16] = b2;
    req   = 4'b0100;
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({ack, tx_start, busy, grant_id, err_timeout} !== '0 || tx_data !== '0) begin
      failures++; $display("FAIL mid_reset_outputs: ack=%b start=%b busy=%b id=%0d err=%b data=%h want all 0",
                           ack, tx_start, busy, grant_id, err_timeout, tx_data);
    end
    reset = 1'b0;
    ptr_m = N_REQ - 1;
    s0 = starts; early = 1'b0; ok = 1'b0;
    for (int c = 0; c < FRAME_BUDGET; c++) begin
      if (tx_ready === 1'b1) begin ok = 1'b1; break; end
      if (tx_start === 1'b1 || busy === 1'b1) early = 1'b1;
      @(negedge clk);
    end
    checks++; if (!ok || early || starts != s0) begin
      failures++; $display("FAIL mid_hold_off: ready=%b early=%b starts=%0d want 1/0/0", ok, early, starts - s0);
    end
    w = model_pick(req); ptr_m = w;
    wait_ack(10, ok);
    checks++; if (!ok || ack !== onehot(w) || grant_id !== IDX_W'(w)) begin
      failures++; $display("FAIL mid_pending: ack=%b id=%0d want %b/%0d", ack, grant_id, onehot(w), w);
    end
    req = '0;
    wait_idle(FRAME_BUDGET, ok);
    checks++; if (!ok || rx_q.size() != 2 || rx_q[0] !== b0 || rx_q[1] !== b2) begin
      failures++; $display("FAIL mid_frames: got %0d frames want %h,%h", rx_q.size(), b0, b2);
    end
  endtask

  task automatic test_drop_before_ack();
    bit ok, saw; int w, s0;
    rx_q.delete();
    s0 = starts;
    req_data[7:0] = 8'($urandom);
    req = 4'b0001;
    w = model_pick(req); ptr_m = w;
    wait_ack(10, ok);
    checks++; if (!ok || ack !== onehot(w)) begin failures++; $display("FAIL drop_first_ack: got %b want %b", ack, onehot(w)); end
    req = '0;
    tick(2 * CPB);
    req_data[15:8] = 8'hEE;
    req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    saw = 1'b0;
    for (int c = 0; c < FRAME_BUDGET; c++) begin
      @(negedge clk);
      if (ack[1] === 1'b1) saw = 1'b1;
    end
    checks++; if (saw) begin failures++; $display("FAIL drop_ack1: got ack[1]=1 want 0"); end
    checks++; if (starts - s0 != 1 || rx_q.size() != 1) begin
      failures++; $display("FAIL drop_frames: starts=%0d frames=%0d want 1/1", starts - s0, rx_q.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int round = 0; round < 4; round++) begin
      int cnt[N_REQ]; int rem[N_REQ]; int pos[N_REQ];
      logic [7:0] bytes[N_REQ][4];
      int exp_id[$]; logic [7:0] exp_b[$];
      int total, p;
      total = 0;
      for (int i = 0; i < N_REQ; i++) begin
        cnt[i] = int'($urandom_range(0, 3));
        for (int j = 0; j < 4; j++) bytes[i][j] = 8'($urandom);
        total += cnt[i];
      end
      if (total == 0) begin cnt[round % N_REQ] = 1; total = 1; end
      rem = cnt;
      p = ptr_m;
      while (exp_id.size() < total) begin
        for (int k = 1; k <= N_REQ; k++) begin
          int i;
          i = (p + k) % N_REQ;
          if (rem[i] > 0) begin
            exp_id.push_back(i);
            exp_b.push_back(bytes[i][cnt[i] - rem[i]]);
            rem[i]--;
            p = i;
            break;
          end
        end
      end
      ptr_m = p;
      rx_q.delete();
      for (int i = 0; i < N_REQ; i++) begin
        pos[i] = 0;
        req_data[i*DW +: DW] = bytes[i][0];
        req[i] = (cnt[i] > 0);
      end
      for (int n = 0; n < total; n++) begin
        wait_ack(FRAME_BUDGET, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rand_ack_wait[%0d.%0d]: no ack", round, n); break; end
        checks++; if (ack !== onehot(exp_id[n])) begin
          failures++; $display("FAIL rand_ack[%0d.%0d]: got %b want %b", round, n, ack, onehot(exp_id[n]));
        end
        for (int i = 0; i < N_REQ; i++) begin
          if (ack[i] === 1'b1) begin
            pos[i]++;
            if (pos[i] < cnt[i]) req_data[i*DW +: DW] = bytes[i][pos[i]];
            else req[i] = 1'b0;
          end
        end
      end
      req = '0;
      wait_idle(FRAME_BUDGET, ok);
      checks++; if (!ok || rx_q.size() != total) begin
        failures++; $display("FAIL rand_frames[%0d]: got %0d want %0d", round, rx_q.size(), total);
      end else begin
        for (int n = 0; n < total; n++) begin
          checks++; if (rx_q[n] !== exp_b[n]) begin
            failures++; $display("FAIL rand_byte[%0d.%0d]: got %h want %h", round, n, rx_q[n], exp_b[n]);
          end
        end
      end
    end
    checks++; if (frame_errs != 0) begin failures++; $display("FAIL framing_total: got %0d errors want 0", frame_errs); end
  endtask

  initial begin
    reset    = 1'b1;
    req      = '0;
    req_data = '0;
    m_rst    = 1'b1;
    m_stuck  = 1'b0;
    ptr_m    = N_REQ - 1;
    tick(3);
    m_rst = 1'b0;
    test_reset();
    test_single();
    test_all_requesters();
    test_wrap();
    test_stuck();
    test_reset_mid_frame();
    test_drop_before_ack();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
